uart_tx_scheduler: RTL and testbench

//  Shares one UART transmitter (UART1 TX path of SYSTEM_TOP) between NUM_REQ byte sources.
//  - Round-robin arbitration, one byte per grant.
//  - Sequences the line driver enable (TXD_EN) with lead/lag guard times for RS-485 style

---
 rtl/uart_tx_scheduler_if.sv | 35 +++
 rtl/uart_tx_scheduler.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_if.sv
// ============================================================================
// Module  : uart_tx_scheduler_if
// Brief   : Requester-side and transmitter-side signals of the UART TX scheduler
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
) ();
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_busy;
    logic                 txd_en;
    logic [GW-1:0]        grant_id;
    logic                 active;

    modport master (
        input  req_valid, req_data, tx_ready, tx_busy,
        output req_ready, tx_data, tx_valid, txd_en, grant_id, active
    );

    modport slave (
        output req_valid, req_data, tx_ready, tx_busy,
        input  req_ready, tx_data, tx_valid, txd_en, grant_id, active
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
// Module  : uart_tx_scheduler
// Brief   : Round-robin byte arbiter in front of one UART TX, with RS-485 style
//           driver-enable lead/lag guard sequencing
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int LEAD_CYC = 16,
    parameter int LAG_CYC  = 32
) (
    input  logic                hclk,
    input  logic                hreset,
    uart_tx_scheduler_if.master bus
);
    localparam int GW   = $clog2(NUM_REQ);
    localparam int MAXC = (LEAD_CYC > LAG_CYC) ? LEAD_CYC : LAG_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] C_LEAD_LOAD = CW'((LEAD_CYC > 0) ? LEAD_CYC - 1 : 0);
    localparam logic [CW-1:0] C_LAG_LOAD  = CW'((LAG_CYC > 0) ? LAG_CYC - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEAD = 3'd1,
        S_ARB  = 3'd2,
        S_SEND = 3'd3,
        S_WAIT = 3'd4,
        S_LAG  = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic                 r_wait_first, w_wait_first_nxt;
    logic [GW-1:0]        r_ptr;
    logic [7:0]           r_tx_data;
    logic                 r_tx_valid;
    logic [NUM_REQ-1:0]   r_req_ready;
    logic [GW-1:0]        r_grant_id;
    logic                 r_active;

    logic                 w_any;
    logic                 w_found;
    logic [GW-1:0]        w_win;
    logic [7:0]           w_win_data;
    logic                 w_grant;

    assign w_any = |bus.req_valid;

    // Rotating priority search starting at the round-robin pointer.
    always_comb begin
        logic [GW-1:0] idx;
        idx        = '0;
        w_found    = 1'b0;
        w_win      = '0;
        w_win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = GW'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && bus.req_valid[idx]) begin
                w_found = 1'b1;
                w_win   = idx;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == GW'(i)) begin
                w_win_data = bus.req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_wait_first_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    if (LEAD_CYC == 0) begin
                        w_state_nxt = S_ARB;
                    end else begin
                        w_state_nxt = S_LEAD;
                        w_cnt_nxt   = C_LEAD_LOAD;
                    end
                end
            end
            S_LEAD: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (w_any) begin
                    w_state_nxt = S_ARB;
                end else begin
                    // Requester withdrew during the lead time: release the line normally.
                    w_state_nxt = (LAG_CYC == 0) ? S_IDLE : S_LAG;
                    w_cnt_nxt   = C_LAG_LOAD;
                end
            end
            S_ARB: begin
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (r_tx_valid && bus.tx_ready) begin
                    w_state_nxt      = S_WAIT;
                    w_wait_first_nxt = 1'b1;
                end
            end
            S_WAIT: begin
                // TX_BUSY only rises the cycle after accept, so the first WAIT cycle is skipped.
                if (!r_wait_first && !bus.tx_busy) begin
                    if (w_any) begin
                        w_state_nxt = S_ARB;
                    end else begin
                        w_state_nxt = (LAG_CYC == 0) ? S_IDLE : S_LAG;
                        w_cnt_nxt   = C_LAG_LOAD;
                    end
                end
            end
            S_LAG: begin
                if (w_any) begin
                    w_state_nxt = S_ARB;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // The grant is registered on entry to ARB so REQ_READY and TX_DATA are visible during ARB.
    assign w_grant = (w_state_nxt == S_ARB) && w_found;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_wait_first <= 1'b0;
            r_ptr        <= '0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_req_ready  <= '0;
            r_grant_id   <= '0;
            r_active     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_wait_first <= w_wait_first_nxt;
            r_tx_valid   <= (w_state_nxt == S_SEND);
            r_active     <= (w_state_nxt != S_IDLE);
            r_req_ready  <= '0;
            if (w_grant) begin
                r_req_ready <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
                r_tx_data   <= w_win_data;
                r_grant_id  <= w_win;
                r_ptr       <= (w_win == GW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
            end
        end
    end

    assign bus.tx_data   = r_tx_data;
    assign bus.tx_valid  = r_tx_valid;
    assign bus.req_ready = r_req_ready;
    assign bus.grant_id  = r_grant_id;
    assign bus.active    = r_active;
    assign bus.txd_en    = r_active;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// ============================================================================
// Module  : tb_uart_tx_scheduler
// Brief   : Directed self-checking bench for uart_tx_scheduler (4 requesters, 16/32 guard)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_scheduler;
    logic clk;
    logic hreset;
    int   checks = 0;
    int   errors = 0;

    uart_tx_scheduler_if #(.NUM_REQ(4)) bus ();

    uart_tx_scheduler #(
        .NUM_REQ (4),
        .LEAD_CYC(16),
        .LAG_CYC (32)
    ) dut (
        .hclk  (clk),
        .hreset(hreset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_txd_en"},    32'(bus.txd_en),    32'd0);
        chk({tag, "_tx_valid"},  32'(bus.tx_valid),  32'd0);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_active"},    32'(bus.active),    32'd0);
        chk({tag, "_tx_data"},   32'(bus.tx_data),   32'd0);
        chk({tag, "_grant_id"},  32'(bus.grant_id),  32'd0);
    endtask

    // Entered at the ARB cycle; leaves one cycle after TX_BUSY falls.
    task automatic frame(input int id, input logic [7:0] d, input logic [3:0] clr);
        logic [3:0] onehot;
        onehot = 4'b0001 << id;
        chk("arb_req_ready", 32'(bus.req_ready), 32'(onehot));
        chk("arb_grant_id",  32'(bus.grant_id),  32'(id));
        chk("arb_tx_data",   32'(bus.tx_data),   32'(d));
        chk("arb_txd_en",    32'(bus.txd_en),    32'd1);
        chk("arb_tx_valid",  32'(bus.tx_valid),  32'd0);
        bus.req_valid = bus.req_valid & ~clr;
        step();
        chk("send_tx_valid",  32'(bus.tx_valid),  32'd1);
        chk("send_tx_data",   32'(bus.tx_data),   32'(d));
        chk("send_req_ready", 32'(bus.req_ready), 32'd0);
        bus.tx_ready = 1'b1;
        step();
        bus.tx_ready = 1'b0;
        chk("wait_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("wait_txd_en",   32'(bus.txd_en),   32'd1);
        bus.tx_busy = 1'b1;
        repeat (3) step();
        chk("busy_txd_en", 32'(bus.txd_en), 32'd1);
        bus.tx_busy = 1'b0;
        step();
    endtask

    initial begin
        hreset        = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_ready  = 1'b0;
        bus.tx_busy   = 1'b0;
        step();
        step();
        chk_reset_values("reset");
        hreset = 1'b0;

        // Single byte from requester 0 with full lead and lag
        bus.req_data  = 32'h0000_00A5;
        bus.req_valid = 4'b0001;
        step();
        chk("t1_txd_en_rise", 32'(bus.txd_en),    32'd1);
        chk("t1_active",      32'(bus.active),    32'd1);
        chk("t1_no_ready",    32'(bus.req_ready), 32'd0);
        repeat (15) step();
        chk("t1_c16_no_ready", 32'(bus.req_ready), 32'd0);
        chk("t1_c16_no_valid", 32'(bus.tx_valid),  32'd0);
        step();
        frame(0, 8'hA5, 4'b0001);
        chk("t1_lag_start", 32'(bus.txd_en), 32'd1);
        repeat (31) step();
        chk("t1_lag_end", 32'(bus.txd_en), 32'd1);
        step();
        chk("t1_txd_off", 32'(bus.txd_en), 32'd0);
        chk("t1_idle",    32'(bus.active), 32'd0);

        // Reset pointer, then four requesters held continuously
        hreset = 1'b1;
        step();
        hreset = 1'b0;
        bus.req_data  = 32'h1312_1110;
        bus.req_valid = 4'b1111;
        repeat (17) step();
        frame(0, 8'h10, 4'b0000);
        frame(1, 8'h11, 4'b0000);
        frame(2, 8'h12, 4'b0000);
        frame(3, 8'h13, 4'b0000);
        frame(0, 8'h10, 4'b0000);
        frame(1, 8'h11, 4'b1111);

        // Pointer now 2: request arriving 5 cycles into LAG wraps to 0 then 1
        chk("t4_lag_txd_en", 32'(bus.txd_en), 32'd1);
        repeat (4) step();
        bus.req_valid = 4'b0011;
        step();
        frame(0, 8'h10, 4'b0001);
        frame(1, 8'h11, 4'b0010);

        // Request on the exact LAG expiry edge
        repeat (31) step();
        chk("t4_expiry_txd_en", 32'(bus.txd_en), 32'd1);
        bus.req_valid = 4'b0100;
        step();
        frame(2, 8'h12, 4'b0100);
        repeat (32) step();
        chk("t4_final_txd_off", 32'(bus.txd_en), 32'd0);
        chk("t4_final_idle",    32'(bus.active), 32'd0);

        // Transmitter stalls in SEND for 100 cycles
        bus.req_data  = 32'h3C00_0000;
        bus.req_valid = 4'b1000;
        repeat (17) step();
        chk("t6_req_ready", 32'(bus.req_ready), 32'b1000);
        chk("t6_grant_id",  32'(bus.grant_id),  32'd3);
        chk("t6_arb_data",  32'(bus.tx_data),   32'h3C);
        bus.req_valid = 4'b0000;
        step();
        for (int i = 0; i < 100; i++) begin
            chk("t6_stall_valid", 32'(bus.tx_valid),  32'd1);
            chk("t6_stall_data",  32'(bus.tx_data),   32'h3C);
            chk("t6_stall_ready", 32'(bus.req_ready), 32'd0);
            bus.req_data  = 32'($urandom);
            bus.req_valid = 4'($urandom_range(15, 0));
            step();
        end
        bus.tx_ready = 1'b1;
        step();
        bus.tx_ready = 1'b0;
        chk("t6_accepted", 32'(bus.tx_valid), 32'd0);
        bus.tx_busy = 1'b1;
        repeat (2) step();

        // Reset in WAIT with the driver enabled
        chk("t5_pre_txd_en", 32'(bus.txd_en), 32'd1);
        hreset = 1'b1;
        step();
        hreset = 1'b0;
        bus.tx_busy = 1'b0;
        chk_reset_values("t5_abort");
        bus.req_data  = 32'h0000_005A;
        bus.req_valid = 4'b0001;
        step();
        chk("t5_lead_txd_en", 32'(bus.txd_en), 32'd1);
        repeat (15) step();
        chk("t5_c16_no_ready", 32'(bus.req_ready), 32'd0);
        step();
        frame(0, 8'h5A, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
